// File: rtl/fbs_sequencer.sv
// fbs_sequencer: sequences backup (push) and restore (pop) requests onto an
// external F-register backup cache. One request is accepted at a time; the
// cache is driven with single-cycle strobes and restored data is returned with
// a one-cycle rst_valid pulse.
// Optional build macro FBS_SEQ_CHECK_EN: enables overflow/underflow checking
// with a sticky err flag. Without it err is tied low and depth wraps.
module fbs_sequencer #(
  parameter int DATA_W = 256,
  parameter int DEPTH  = 16,
  parameter int RD_LAT = 0,
  localparam int D_W   = $clog2(DEPTH) + 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  input  logic              req_op,
  output logic              req_ready,
  input  logic [DATA_W-1:0] snap_in,
  output logic [DATA_W-1:0] rst_data,
  output logic              rst_valid,
  output logic              fbs_backup,
  output logic              fbs_restore,
  output logic [DATA_W-1:0] fbs_dataIn,
  input  logic [DATA_W-1:0] fbs_dataOut,
  output logic [D_W-1:0]    depth,
  output logic              busy,
  output logic              err
);

`ifdef FBS_SEQ_CHECK_EN
  localparam bit CHECK_EN = 1'b1;
`else
  localparam bit CHECK_EN = 1'b0;
`endif

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    BACKUP  = 3'd1,
    RESTORE = 3'd2,
    WAIT    = 3'd3,
    DONE    = 3'd4
  } state_t;

  // RESTORE itself covers no read latency, so WAIT counts RD_LAT-1 down to 0.
  localparam bit             LAT0      = (RD_LAT == 0);
  localparam logic [1:0]     WAIT_INIT = (RD_LAT > 1) ? 2'(RD_LAT - 1) : 2'd0;
  localparam logic [D_W-1:0] DEPTH_MAX = D_W'(DEPTH);

  state_t              state_q, state_d;
  logic [D_W-1:0]      depth_q, depth_d;
  logic [DATA_W-1:0]   wr_q, wr_d;
  logic [DATA_W-1:0]   rst_data_q, rst_data_d;
  logic                rst_valid_q, rst_valid_d;
  logic                fbs_backup_q, fbs_backup_d;
  logic                fbs_restore_q, fbs_restore_d;
  logic                ready_q, ready_d;
  logic                busy_q, busy_d;
  logic                err_q, err_d;
  logic                abort_q, abort_d;
  logic [1:0]          wait_cnt_q, wait_cnt_d;

  // Next-state and next-output computation; all outputs are registered copies.
  always_comb begin
    state_d    = state_q;
    depth_d    = depth_q;
    wr_d       = wr_q;
    rst_data_d = rst_data_q;
    err_d      = err_q;
    abort_d    = abort_q;
    wait_cnt_d = wait_cnt_q;

    case (state_q)
      IDLE: begin
        abort_d = 1'b0;
        if (req_valid) begin
          if (!req_op) begin
            wr_d    = snap_in;
            state_d = BACKUP;
            // A full cache turns the backup into a strobe-less error cycle.
            if (CHECK_EN && (depth_q == DEPTH_MAX)) begin
              abort_d = 1'b1;
              err_d   = 1'b1;
            end
          end else begin
            state_d = RESTORE;
            // An empty cache turns the restore into a strobe-less error cycle.
            if (CHECK_EN && (depth_q == '0)) begin
              abort_d = 1'b1;
              err_d   = 1'b1;
            end
          end
        end
      end
      BACKUP: begin
        state_d = IDLE;
        if (!abort_q) begin
          depth_d = depth_q + D_W'(1);
        end
      end
      RESTORE: begin
        if (abort_q) begin
          state_d = IDLE;
        end else begin
          depth_d = depth_q - D_W'(1);
          if (LAT0) begin
            rst_data_d = fbs_dataOut;
            state_d    = DONE;
          end else begin
            wait_cnt_d = WAIT_INIT;
            state_d    = WAIT;
          end
        end
      end
      WAIT: begin
        if (wait_cnt_q == 2'd0) begin
          rst_data_d = fbs_dataOut;
          state_d    = DONE;
        end else begin
          wait_cnt_d = wait_cnt_q - 2'd1;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // Strobes are only issued in their own state, and never for an error cycle.
    fbs_backup_d  = (state_d == BACKUP)  && !abort_d;
    fbs_restore_d = (state_d == RESTORE) && !abort_d;
    rst_valid_d   = (state_d == DONE);
    ready_d       = (state_d == IDLE);
    busy_d        = (state_d != IDLE);
  end

  // State register with synchronous reset; reset aborts any operation in flight.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= IDLE;
      depth_q       <= '0;
      wr_q          <= '0;
      rst_data_q    <= '0;
      rst_valid_q   <= 1'b0;
      fbs_backup_q  <= 1'b0;
      fbs_restore_q <= 1'b0;
      ready_q       <= 1'b1;
      busy_q        <= 1'b0;
      err_q         <= 1'b0;
      abort_q       <= 1'b0;
      wait_cnt_q    <= 2'd0;
    end else begin
      state_q       <= state_d;
      depth_q       <= depth_d;
      wr_q          <= wr_d;
      rst_data_q    <= rst_data_d;
      rst_valid_q   <= rst_valid_d;
      fbs_backup_q  <= fbs_backup_d;
      fbs_restore_q <= fbs_restore_d;
      ready_q       <= ready_d;
      busy_q        <= busy_d;
      err_q         <= err_d;
      abort_q       <= abort_d;
      wait_cnt_q    <= wait_cnt_d;
    end
  end

  assign req_ready   = ready_q;
  assign rst_data    = rst_data_q;
  assign rst_valid   = rst_valid_q;
  assign fbs_backup  = fbs_backup_q;
  assign fbs_restore = fbs_restore_q;
  assign fbs_dataIn  = wr_q;
  assign depth       = depth_q;
  assign busy        = busy_q;

`ifdef FBS_SEQ_CHECK_EN
  assign err = err_q;
`else
  assign err = 1'b0;
`endif

endmodule
